// File: rtl/button_pkg.sv
// Shared constants and helpers for the push-button debouncer.
package button_pkg;

  localparam int unsigned DEBOUNCE_10MS_50MHZ = 500000;

  // Raw pin level while the button is not pressed.
  function automatic logic idle_level(input bit active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button bundle between the raw pins, the debouncer and its consumers.
interface button_debouncer_if #(
  parameter int unsigned WIDTH = 4
);

  logic [WIDTH-1:0] btn_raw;
  logic [WIDTH-1:0] btn_level;
  logic [WIDTH-1:0] btn_press;
  logic [WIDTH-1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );

endinterface

// File: rtl/debounce_channel.sv
// One button: 2-flop synchronizer, stability counter, debounced level and
// single-cycle press/release strobes.
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_i,
  output logic btn_level_o,
  output logic btn_press_o,
  output logic btn_release_o
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             IDLE    = idle_level(ACTIVE_LOW);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             pressed;

  // Sync flops reset to the idle pin level so release never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= IDLE;
      sync2_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign pressed = sync2_q ^ ACTIVE_LOW;

  // Any sample agreeing with the current level restarts the stability window.
  always_comb begin
    sync1_d   = btn_raw_i;
    sync2_d   = sync1_q;
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (pressed != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d   = pressed;
        press_d   = pressed;
        release_d = ~pressed;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign btn_level_o   = level_q;
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;

  a_strobe_exclusive : assert property (@(posedge clk) disable iff (reset)
    !(press_q && release_q));

  a_cnt_bounded : assert property (@(posedge clk) disable iff (reset)
    cnt_q <= CNT_MAX);

endmodule

// File: rtl/button_debouncer.sv
// Debounces WIDTH independent push-buttons; output 1 = pressed.
module button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  button_debouncer_if.slave   btn
);

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .btn_raw_i     (btn.btn_raw[i]),
      .btn_level_o   (btn.btn_level[i]),
      .btn_press_o   (btn.btn_press[i]),
      .btn_release_o (btn.btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: a window-based reference model
// predicts every cycle's outputs; a monitor compares them after each edge.
module tb_button_debouncer;

  localparam int unsigned W  = 4;
  localparam int unsigned DC = 4;

  typedef struct packed {
    logic [W-1:0] level;
    logic [W-1:0] press;
    logic [W-1:0] rel;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  button_debouncer_if #(.WIDTH(W)) bus ();

  button_debouncer #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   armed = 1'b0;
  exp_t exp_q[$];

  // Reference model: raw samples seen at recent edges, and per channel the
  // pressed samples observed since the last accepted change.
  logic [W-1:0] raw_hist[$];
  logic [W-1:0] m_level;
  bit           win[W][$];

  task automatic model_edge(input logic [W-1:0] raw, input bit in_reset);
    exp_t         e;
    logic [W-1:0] pressed;
    bit           all_diff;
    e = '0;
    if (in_reset) begin
      raw_hist = '{ {W{1'b1}}, {W{1'b1}} };
      for (int i = 0; i < int'(W); i++) win[i].delete();
      m_level = '0;
    end else begin
      // What the channel sees now is what the pin showed two edges ago.
      pressed = ~raw_hist[0];
      raw_hist.push_back(raw);
      void'(raw_hist.pop_front());
      for (int i = 0; i < int'(W); i++) begin
        win[i].push_back(pressed[i]);
        if (win[i].size() > int'(DC)) void'(win[i].pop_front());
        all_diff = (win[i].size() == int'(DC));
        for (int j = 0; j < win[i].size(); j++)
          if (win[i][j] == m_level[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[i] = pressed[i];
          e.press[i] = pressed[i];
          e.rel[i]   = ~pressed[i];
          win[i].delete();
        end
      end
      e.level = m_level;
    end
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus and predict the response to the next edge.
  task automatic step(input logic [W-1:0] raw, input bit rst);
    @(negedge clk);
    bus.btn_raw = raw;
    reset       = rst;
    model_edge(raw, rst);
    armed = 1'b1;
    cyc++;
  endtask

  task automatic check_now(input string name, input exp_t want);
    exp_t got;
    got = {bus.btn_level, bus.btn_press, bus.btn_release};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got lvl=%h prs=%h rel=%h want lvl=%h prs=%h rel=%h",
               name, cyc, got.level, got.press, got.rel, want.level, want.press, want.rel);
    end
  endtask

  // Monitor: one prediction per edge once stimulus has started.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (armed) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard_underflow cyc=%0d got empty queue want entry", cyc);
        end else begin
          check_now("edge", exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got timeout want completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] r;
    int           hold[W];

    reset       = 1'b1;
    bus.btn_raw = '1;

    // 1: reset with buttons idle, then idle
    repeat (3)  step(4'hF, 1'b1);
    repeat (20) step(4'hF, 1'b0);
    // 2: press button 0 and hold
    repeat (10) step(4'hE, 1'b0);
    // 3: short glitch on button 1, then bounce before a held press
    repeat (3)  step(4'hC, 1'b0);
    repeat (8)  step(4'hE, 1'b0);
    repeat (2)  step(4'hC, 1'b0);
    step(4'hE, 1'b0);
    repeat (10) step(4'hC, 1'b0);
    // 4: release button 0, then button 1
    repeat (10) step(4'hD, 1'b0);
    repeat (10) step(4'hF, 1'b0);
    // 5: two buttons pressed in the same cycle
    repeat (10) step(4'h5, 1'b0);
    // 6: reset mid-debounce with buttons held through reset
    repeat (4)  step(4'h4, 1'b0);
    step(4'h4, 1'b1);
    #1;
    check_now("async_reset", '0);
    repeat (2)  step(4'h4, 1'b1);
    repeat (10) step(4'h4, 1'b0);

    // Random bouncing with occasional resets
    r = 4'h4;
    for (int i = 0; i < int'(W); i++) hold[i] = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < int'(W); i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          r[i]    = ~r[i];
          hold[i] = int'($urandom_range(1, 2 * DC + 3));
        end
      end
      if ($urandom_range(0, 399) == 0) begin
        step(r, 1'b1);
        #1;
        check_now("async_reset_rand", '0);
        step(r, 1'b1);
      end else begin
        step(r, 1'b0);
      end
    end
    repeat (12) step(4'hF, 1'b0);

    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
